// File: rtl/weight_loader_pkg.sv
// Shared definitions for the layer weight loader: stream word layout,
// header field positions and FSM state encoding.
package weight_loader_pkg;

    // Every stream beat is a 32-bit word, either a header or a weight.
    localparam int STREAM_W = 32;

    // Header word layout.
    localparam int HDR_LAYER_MSB  = 31;
    localparam int HDR_LAYER_LSB  = 16;
    localparam int HDR_NEURON_MSB = 15;
    localparam int HDR_NEURON_LSB = 0;

    // Loader states. ST_CHK is only reachable in checksum builds.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SKIP = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [15:0] hdr_layer(input logic [STREAM_W-1:0] word);
        return word[HDR_LAYER_MSB:HDR_LAYER_LSB];
    endfunction

    function automatic logic [15:0] hdr_neuron(input logic [STREAM_W-1:0] word);
        return word[HDR_NEURON_MSB:HDR_NEURON_LSB];
    endfunction

endpackage

// File: rtl/weight_loader_neuron_sel_decoder.sv
// neuron_sel_decoder: latches the neuron index of an accepted header as a
// one-hot select and produces the registered per-memory write enables.
// The index is validated upstream, so it is always below numNeurons here.
module neuron_sel_decoder #(
    parameter int numNeurons = 30,
    parameter int IDX_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_load,
    input  logic [IDX_W-1:0]      sel_idx,
    input  logic                  wr,
    output logic [numNeurons-1:0] wen
);

    logic [numNeurons-1:0] sel_onehot;
    logic [numNeurons-1:0] onehot_next;

    // Decode the incoming header index into a one-hot select.
    always_comb begin
        onehot_next = '0;
        for (int i = 0; i < numNeurons; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                onehot_next[i] = 1'b1;
            end
        end
    end

    // Hold the selected neuron for the whole weight burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_onehot <= '0;
        end else if (sel_load) begin
            sel_onehot <= onehot_next;
        end
    end

    // Registered write enable: one bit, one cycle per accepted weight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen <= '0;
        end else begin
            wen <= wr ? sel_onehot : '0;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams header + weight words into the per-neuron weight
// memories of one layer through a registered wen/wadd/win write port.
// Build option: define WLOAD_CHECKSUM_EN to expect one checksum word after
// each neuron's weights; a checksum mismatch sets the sticky err flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a header word
// LOAD    | writing weights of the selected neuron, address = counter
// SKIP    | bad header: discarding numWeight words without writing
// CHK     | expecting the checksum word (checksum builds only)
// DONE    | one-cycle gap with s_ready low, load_done follows
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int numWeight    = 784,
    parameter int numNeurons   = 30,
    parameter int layerNo      = 1,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic [STREAM_W-1:0]     s_data,
    output logic                    s_ready,
    output logic [numNeurons-1:0]   wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    load_done,
    output logic                    err
);

    localparam int IDX_W = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    state_t                  state;
    state_t                  next_state;
    logic [addressWidth-1:0] cnt;
    logic                    accept;
    logic                    hdr_ok;
    logic                    cnt_clr;
    logic                    cnt_inc;
    logic                    wr;
    logic                    sel_load;
    logic                    err_set;
    logic [dataWidth-1:0]    word_data;

`ifdef WLOAD_CHECKSUM_EN
    logic [dataWidth-1:0]    csum_acc;
`endif

    // Ready drops during reset and for the single DONE cycle.
    assign s_ready   = !rst && (state != ST_DONE);
    assign accept    = s_valid && s_ready;
    assign word_data = s_data[dataWidth-1:0];
    assign hdr_ok    = (hdr_layer(s_data) == 16'(layerNo)) &&
                       (hdr_neuron(s_data) < 16'(numNeurons));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-beat control strobes.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        wr         = 1'b0;
        sel_load   = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_clr = 1'b1;
                    if (hdr_ok) begin
                        sel_load   = 1'b1;
                        next_state = ST_LOAD;
                    end else begin
                        err_set    = 1'b1;
                        next_state = ST_SKIP;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr = 1'b1;
                    if (cnt == LAST_ADDR) begin
`ifdef WLOAD_CHECKSUM_EN
                        next_state = ST_CHK;
`else
                        next_state = ST_DONE;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (accept) begin
                    if (cnt == LAST_ADDR) begin
                        next_state = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`ifdef WLOAD_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    err_set    = (csum_acc != word_data);
                    next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Word counter: cleared by every header, stops at the last address.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shared write address/data, registered alongside wen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wadd <= '0;
            win  <= '0;
        end else if (wr) begin
            wadd <= cnt;
            win  <= word_data;
        end
    end

    // load_done trails the DONE state by one cycle, landing right after
    // the final wen cycle of the neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_done <= 1'b0;
        end else begin
            load_done <= (state == ST_DONE);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    // Running mod-2^dataWidth sum of the current neuron's weights.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_acc <= '0;
        end else if (cnt_clr) begin
            csum_acc <= '0;
        end else if (wr) begin
            csum_acc <= csum_acc + word_data;
        end
    end
`endif

    neuron_sel_decoder #(
        .numNeurons (numNeurons),
        .IDX_W      (IDX_W)
    ) u_sel_dec (
        .clk      (clk),
        .rst      (rst),
        .sel_load (sel_load),
        .sel_idx  (IDX_W'(hdr_neuron(s_data))),
        .wr       (wr),
        .wen      (wen)
    );

endmodule

// File: tb/tb_weight_loader.sv
// Testbench for weight_loader: directed packets from the test plan plus
// randomized packets, checked by a scoreboard of expected writes and
// load_done pulses. Honours WLOAD_CHECKSUM_EN when defined.
module tb_weight_loader;

    localparam int NW = 4;
    localparam int NN = 3;
    localparam int LN = 1;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_ready;
    logic [NN-1:0] wen;
    logic [AW-1:0] wadd;
    logic [DW-1:0] win;
    logic          load_done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit model_err = 1'b0;

    typedef struct {
        int            cyc;
        logic [NN-1:0] oh;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    weight_loader #(
        .numWeight    (NW),
        .numNeurons   (NN),
        .layerNo      (LN),
        .addressWidth (AW),
        .dataWidth    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wen       (wen),
        .wadd      (wadd),
        .win       (win),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every write-port beat and load_done pulse against
    // the expectations queued by the stimulus side.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_w;
            bit exp_d;
            wr_t e;
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL write_missing: no write seen, expected addr %0d data %0h", wq[0].addr, wq[0].data);
                void'(wq.pop_front());
            end
            exp_w = (wq.size() > 0) && (wq[0].cyc == cyc);
            if (wen !== '0 || exp_w) begin
                checks++;
                if (!exp_w) begin
                    errors++;
                    $display("FAIL write_spurious: got wen %b wadd %0d win %0h, expected no write", wen, wadd, win);
                end else begin
                    e = wq.pop_front();
                    if ({wen, wadd, win} !== {e.oh, e.addr, e.data}) begin
                        errors++;
                        $display("FAIL write: got wen %b wadd %0d win %0h, expected wen %b wadd %0d win %0h",
                                 wen, wadd, win, e.oh, e.addr, e.data);
                    end
                end
            end
            while (dq.size() > 0 && dq[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL load_done_missing: expected pulse in cycle %0d", dq[0]);
                void'(dq.pop_front());
            end
            exp_d = (dq.size() > 0) && (dq[0] == cyc);
            if (load_done !== 1'b0 || exp_d) begin
                checks++;
                if (!(load_done === 1'b1 && exp_d)) begin
                    errors++;
                    $display("FAIL load_done: got %b expected %b (cycle %0d)", load_done, exp_d, cyc);
                end
                if (exp_d) void'(dq.pop_front());
            end
        end
    end

    // Watchdog so a stuck design still reaches the summary line.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        summary();
        $fatal(1, "time limit");
    end

    // Present one word, wait (bounded) for acceptance, return #1 after the
    // accepting edge with s_valid dropped.
    task automatic send_word(input logic [31:0] data);
        int n = 0;
        s_valid = 1'b1;
        s_data  = data;
        forever begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            n++;
            if (n > 20) begin
                errors++;
                $display("FAIL ready_timeout: s_ready stayed %b for 20 cycles", s_ready);
                summary();
                $fatal(1, "ready timeout");
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_wadd", 64'(wadd), 64'd0);
        chk("rst_win", 64'(win), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_err = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    endtask

    task automatic push_write(input int neuron, input int addr, input logic [31:0] w);
        wr_t e;
        e.cyc  = cyc;
        e.oh   = '0;
        e.oh[neuron] = 1'b1;
        e.addr = AW'(addr);
        e.data = w[DW-1:0];
        wq.push_back(e);
    endtask

    // One complete packet. A good header yields NW writes to addresses
    // 0..NW-1 and a load_done two cycles after the final accepted beat;
    // a bad header yields no writes, no load_done and a sticky err.
    task automatic send_packet(input int layer, input int neuron, input logic [31:0] w[NW],
                               input int gap[NW], input bit csum_bad);
        bit            good;
        logic [DW-1:0] sum;
        logic [31:0]   hdr;
        good = (layer == LN) && (neuron < NN);
        sum  = '0;
        hdr  = {layer[15:0], neuron[15:0]};
        send_word(hdr);
        if (!good) model_err = 1'b1;
        for (int i = 0; i < NW; i++) begin
            idle(gap[i]);
            send_word(w[i]);
            sum = sum + w[i][DW-1:0];
            if (good) push_write(neuron, i, w[i]);
        end
`ifdef WLOAD_CHECKSUM_EN
        if (good) begin
            send_word({16'h0, csum_bad ? sum + 16'd1 : sum});
            if (csum_bad) model_err = 1'b1;
        end
`else
        if (csum_bad) sum = sum + 16'd0;
`endif
        if (good) begin
            dq.push_back(cyc + 1);
            chk("ready_in_done", 64'(s_ready), 64'd0);
        end else begin
            chk("ready_after_skip", 64'(s_ready), 64'd1);
        end
        chk("err", 64'(err), 64'(model_err));
    endtask

    initial begin
        logic [31:0] w[NW];
        int          g[NW];
        int          kind;
        int          lay;
        int          neu;

        do_reset();
        mon_en = 1'b1;

        // Back-to-back load into neuron 2.
        send_packet(1, 2, '{32'd5, 32'd6, 32'd7, 32'd8}, '{0, 0, 0, 0}, 1'b0);
        // Wrong layer, then a good load with err staying set.
        send_packet(2, 0, '{32'h11, 32'h22, 32'h33, 32'h44}, '{0, 0, 0, 0}, 1'b0);
        send_packet(1, 0, '{32'hAAAA_1234, 32'h0000_FFFF, 32'h5, 32'h8000}, '{0, 0, 0, 0}, 1'b0);
        // Neuron index equal to numNeurons.
        send_packet(1, 3, '{32'h1, 32'h2, 32'h3, 32'h4}, '{1, 0, 0, 0}, 1'b0);
        // s_valid pattern 1,0,0,1 inside the load.
        send_packet(1, 1, '{32'h9, 32'hA, 32'hB, 32'hC}, '{0, 2, 0, 0}, 1'b0);

        // Reset after two of four weights, then a fresh load from wadd 0.
        idle(3);
        send_word({16'd1, 16'd2});
        send_word(32'h0000_0101);
        push_write(2, 0, 32'h0000_0101);
        send_word(32'h0000_0202);
        push_write(2, 1, 32'h0000_0202);
        do_reset();
        send_packet(1, 1, '{32'h31, 32'h32, 32'h33, 32'h34}, '{0, 0, 0, 0}, 1'b0);

`ifdef WLOAD_CHECKSUM_EN
        send_packet(1, 0, '{32'd1, 32'd2, 32'd3, 32'd4}, '{0, 0, 0, 0}, 1'b0);
        send_packet(1, 0, '{32'd1, 32'd2, 32'd3, 32'd4}, '{0, 0, 0, 0}, 1'b1);
`endif

        // Randomized packets with random gaps and header faults.
        for (int p = 0; p < 30; p++) begin
            kind = int'($urandom_range(0, 9));
            lay  = LN;
            neu  = int'($urandom_range(0, NN - 1));
            if (kind == 0) lay = int'($urandom_range(2, 65535));
            if (kind == 1) neu = int'($urandom_range(NN, 65535));
            for (int i = 0; i < NW; i++) begin
                w[i] = $urandom;
                g[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            send_packet(lay, neu, w, g, $urandom_range(0, 3) == 0);
            idle(int'($urandom_range(0, 2)));
            if (p % 10 == 9) begin
                idle(3);
                do_reset();
            end
        end

        idle(5);
        chk("writes_drained", 64'(wq.size()), 64'd0);
        chk("done_drained", 64'(dq.size()), 64'd0);
        summary();
        $finish;
    end

endmodule
